// File: rtl/spart_gen2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spart_gen2
// Purpose  : Processor-bus UART (SPART) with TX/RX FIFOs, runtime frame
//            format (5-8 data bits, optional even/odd parity, 1 or 2 stop
//            bits), programmable baud divisor and sticky error flags.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            iocs_n, iorw_n   - chip select (low), 1=read / 0=write
//            ioaddr[2:0]      - register select
//            databus[7:0]     - bidirectional data, driven during reads
//            RX / TX          - serial in (async) / serial out (idle high)
//            tx_q_full        - TX FIFO full
//            rx_q_empty       - RX FIFO empty
//            irq              - level interrupt (only with SPART_IRQ_EN)
// Options  : SPART_IRQ_EN - adds irq port and the IMSK register.
// Revision : 1.0 - initial release
// ============================================================================
module spart_gen2 #(
    parameter int          TX_DEPTH = 8,
    parameter int          RX_DEPTH = 8,
    parameter logic [15:0] DB_RESET = 16'h0364,
    parameter int          SYNC_FF  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs_n,
    input  logic       iorw_n,
    input  logic [2:0] ioaddr,
    inout  logic [7:0] databus,
    input  logic       RX,
    output logic       TX,
    output logic       tx_q_full,
    output logic       rx_q_empty
`ifdef SPART_IRQ_EN
    ,
    output logic       irq
`endif
);

    localparam int c_TXAW = $clog2(TX_DEPTH);
    localparam int c_RXAW = $clog2(RX_DEPTH);
    localparam logic [c_TXAW:0] c_TX_FULL = (c_TXAW+1)'(TX_DEPTH);
    localparam logic [c_RXAW:0] c_RX_FULL = (c_RXAW+1)'(RX_DEPTH);
    localparam logic [15:0] c_MIN_DIV = 16'd16;

    localparam logic [2:0] c_A_DATA = 3'd0, c_A_STAT = 3'd1, c_A_DBL = 3'd2, c_A_DBH = 3'd3,
                           c_A_CTRL = 3'd4, c_A_TXCNT = 3'd5, c_A_RXCNT = 3'd6, c_A_IMSK = 3'd7;

    localparam logic [2:0] c_TX_IDLE = 3'd0, c_TX_START = 3'd1, c_TX_DATA = 3'd2,
                           c_TX_PAR = 3'd3, c_TX_STOP1 = 3'd4, c_TX_STOP2 = 3'd5;
    localparam logic [2:0] c_RX_IDLE = 3'd0, c_RX_START = 3'd1, c_RX_DATA = 3'd2,
                           c_RX_PAR = 3'd3, c_RX_STOP = 3'd4;

    // ---------------- bus decode and configuration -------------------------
    logic w_wr, w_rd;
    assign w_wr = ~iocs_n & ~iorw_n;
    assign w_rd = ~iocs_n & iorw_n;

    logic [15:0] r_div;
    logic [4:0]  r_ctrl;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= DB_RESET;
            r_ctrl <= 5'h03;
        end else if (w_wr) begin
            case (ioaddr)
                c_A_DBL:  r_div[7:0]  <= databus;
                c_A_DBH:  r_div[15:8] <= databus;
                c_A_CTRL: r_ctrl      <= databus[4:0];
                default:  ;
            endcase
        end
    end

    logic [15:0] w_div_eff;
    assign w_div_eff = (r_div < c_MIN_DIV) ? c_MIN_DIV : r_div;

    // Significant-bit mask for the current data length (parity is computed on it).
    logic [7:0] w_mask;
    always_comb begin
        w_mask = 8'hFF;
        case (r_ctrl[1:0])
            2'd0:    w_mask = 8'h1F;
            2'd1:    w_mask = 8'h3F;
            2'd2:    w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
    end

    // ---------------- TX FIFO ------------------------------------------------
    logic [7:0]        r_tx_mem [TX_DEPTH];
    logic [c_TXAW-1:0] r_tx_wp, r_tx_rp;
    logic [c_TXAW:0]   r_tx_cnt;
    logic [2:0]        r_tx_st;
    logic              w_tx_push, w_tx_pop;
    logic [7:0]        w_tx_head;

    assign tx_q_full = (r_tx_cnt == c_TX_FULL);
    assign w_tx_push = w_wr && (ioaddr == c_A_DATA) && !tx_q_full;
    assign w_tx_pop  = (r_tx_st == c_TX_IDLE) && (r_tx_cnt != '0);
    assign w_tx_head = r_tx_mem[r_tx_rp];

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= databus;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + c_TXAW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_TXAW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + (c_TXAW+1)'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - (c_TXAW+1)'(1);
                default: ;
            endcase
        end
    end

    // ---------------- TX FSM -------------------------------------------------
    logic [15:0] r_tx_div, r_tx_tmr;
    logic [7:0]  r_tx_sh;
    logic [2:0]  r_tx_bit, r_tx_nb;
    logic        r_tx_pen, r_tx_two, r_tx_pbit;
    logic        w_tx_tick;

    assign w_tx_tick = (r_tx_tmr == r_tx_div - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_st   <= c_TX_IDLE;
            r_tx_div  <= c_MIN_DIV;
            r_tx_tmr  <= '0;
            r_tx_sh   <= '0;
            r_tx_bit  <= '0;
            r_tx_nb   <= '0;
            r_tx_pen  <= 1'b0;
            r_tx_two  <= 1'b0;
            r_tx_pbit <= 1'b0;
        end else if (r_tx_st == c_TX_IDLE) begin
            // Frame format and divisor are frozen here for the whole frame.
            if (w_tx_pop) begin
                r_tx_st   <= c_TX_START;
                r_tx_tmr  <= '0;
                r_tx_div  <= w_div_eff;
                r_tx_sh   <= w_tx_head;
                r_tx_bit  <= '0;
                r_tx_nb   <= {1'b0, r_ctrl[1:0]} + 3'd4;
                r_tx_pen  <= r_ctrl[2];
                r_tx_two  <= r_ctrl[4];
                r_tx_pbit <= ^(w_tx_head & w_mask) ^ r_ctrl[3];
            end
        end else begin
            r_tx_tmr <= w_tx_tick ? 16'd0 : r_tx_tmr + 16'd1;
            if (w_tx_tick) begin
                case (r_tx_st)
                    c_TX_START: r_tx_st <= c_TX_DATA;
                    c_TX_DATA: begin
                        r_tx_sh <= r_tx_sh >> 1;
                        if (r_tx_bit == r_tx_nb) r_tx_st <= r_tx_pen ? c_TX_PAR : c_TX_STOP1;
                        else                     r_tx_bit <= r_tx_bit + 3'd1;
                    end
                    c_TX_PAR:   r_tx_st <= c_TX_STOP1;
                    c_TX_STOP1: r_tx_st <= r_tx_two ? c_TX_STOP2 : c_TX_IDLE;
                    default:    r_tx_st <= c_TX_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        TX = 1'b1;
        case (r_tx_st)
            c_TX_START: TX = 1'b0;
            c_TX_DATA:  TX = r_tx_sh[0];
            c_TX_PAR:   TX = r_tx_pbit;
            default:    TX = 1'b1;
        endcase
    end

    // ---------------- RX synchroniser and FSM ---------------------------------
    logic [SYNC_FF-1:0] r_rx_sync;
    logic               r_rx_prev, w_rx_s;
    assign w_rx_s = r_rx_sync[SYNC_FF-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sync <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_sync <= {r_rx_sync[SYNC_FF-2:0], RX};
            r_rx_prev <= w_rx_s;
        end
    end

    logic [2:0]  r_rx_st, r_rx_bit, r_rx_nb;
    logic [15:0] r_rx_div, r_rx_tmr;
    logic [7:0]  r_rx_data;
    logic        r_rx_pen, r_rx_odd, r_rx_perr;
    logic        w_rx_tick, w_rx_stop, w_rx_valid;

    // Start bit is sampled half a bit after the edge; later bits a full bit apart.
    assign w_rx_tick  = (r_rx_st == c_RX_START) ? (r_rx_tmr == (r_rx_div >> 1) - 16'd1)
                                                : (r_rx_tmr == r_rx_div - 16'd1);
    assign w_rx_stop  = (r_rx_st == c_RX_STOP) && w_rx_tick;
    assign w_rx_valid = w_rx_stop && w_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_st   <= c_RX_IDLE;
            r_rx_div  <= c_MIN_DIV;
            r_rx_tmr  <= '0;
            r_rx_data <= '0;
            r_rx_bit  <= '0;
            r_rx_nb   <= '0;
            r_rx_pen  <= 1'b0;
            r_rx_odd  <= 1'b0;
            r_rx_perr <= 1'b0;
        end else if (r_rx_st == c_RX_IDLE) begin
            if (r_rx_prev && !w_rx_s) begin
                r_rx_st   <= c_RX_START;
                r_rx_tmr  <= '0;
                r_rx_div  <= w_div_eff;
                r_rx_data <= '0;
                r_rx_bit  <= '0;
                r_rx_nb   <= {1'b0, r_ctrl[1:0]} + 3'd4;
                r_rx_pen  <= r_ctrl[2];
                r_rx_odd  <= r_ctrl[3];
                r_rx_perr <= 1'b0;
            end
        end else begin
            r_rx_tmr <= w_rx_tick ? 16'd0 : r_rx_tmr + 16'd1;
            if (w_rx_tick) begin
                case (r_rx_st)
                    c_RX_START: r_rx_st <= w_rx_s ? c_RX_IDLE : c_RX_DATA;
                    c_RX_DATA: begin
                        r_rx_data[r_rx_bit] <= w_rx_s;
                        if (r_rx_bit == r_rx_nb) r_rx_st <= r_rx_pen ? c_RX_PAR : c_RX_STOP;
                        else                     r_rx_bit <= r_rx_bit + 3'd1;
                    end
                    c_RX_PAR: begin
                        // Unused high data bits are zero, so they do not disturb the XOR.
                        r_rx_perr <= (w_rx_s != (^r_rx_data ^ r_rx_odd));
                        r_rx_st   <= c_RX_STOP;
                    end
                    default: r_rx_st <= c_RX_IDLE;
                endcase
            end
        end
    end

    // ---------------- RX FIFO ------------------------------------------------
    logic [7:0]        r_rx_mem [RX_DEPTH];
    logic [c_RXAW-1:0] r_rx_wp, r_rx_rp;
    logic [c_RXAW:0]   r_rx_cnt;
    logic              w_rx_full, w_rx_push, w_rx_pop;

    assign rx_q_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == c_RX_FULL);
    assign w_rx_push  = w_rx_valid && !w_rx_full;
    assign w_rx_pop   = w_rd && (ioaddr == c_A_DATA) && !rx_q_empty;

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + c_RXAW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_RXAW'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + (c_RXAW+1)'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - (c_RXAW+1)'(1);
                default: ;
            endcase
        end
    end

    // ---------------- sticky flags (set beats write-1-clear) -----------------
    logic r_ovr, r_frm, r_par, w_w1c;
    assign w_w1c = w_wr && (ioaddr == c_A_STAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr <= 1'b0;
            r_frm <= 1'b0;
            r_par <= 1'b0;
        end else begin
            r_ovr <= (w_rx_valid && w_rx_full) | (r_ovr & ~(w_w1c & databus[3]));
            r_frm <= (w_rx_stop && !w_rx_s)    | (r_frm & ~(w_w1c & databus[2]));
            r_par <= (w_rx_valid && r_rx_perr) | (r_par & ~(w_w1c & databus[1]));
        end
    end

    // ---------------- interrupt ----------------------------------------------
    logic [7:0] w_imsk_rd;
`ifdef SPART_IRQ_EN
    logic [2:0] r_imsk;
    logic       r_irq;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imsk <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && (ioaddr == c_A_IMSK)) r_imsk <= databus[2:0];
            r_irq <= |(r_imsk & {r_ovr | r_frm | r_par, r_tx_cnt == '0, !rx_q_empty});
        end
    end
    assign irq       = r_irq;
    assign w_imsk_rd = {5'b0, r_imsk};
`else
    assign w_imsk_rd = 8'h00;
`endif

    // ---------------- read mux and bus driver --------------------------------
    logic [7:0] w_rdata;
    always_comb begin
        w_rdata = 8'h00;
        case (ioaddr)
            c_A_DATA:  w_rdata = rx_q_empty ? 8'h00 : r_rx_mem[r_rx_rp];
            c_A_STAT:  w_rdata = {4'b0, r_ovr, r_frm, r_par, r_tx_st != c_TX_IDLE};
            c_A_DBL:   w_rdata = r_div[7:0];
            c_A_DBH:   w_rdata = r_div[15:8];
            c_A_CTRL:  w_rdata = {3'b0, r_ctrl};
            c_A_TXCNT: w_rdata = 8'(r_tx_cnt);
            c_A_RXCNT: w_rdata = 8'(r_rx_cnt);
            default:   w_rdata = w_imsk_rd;
        endcase
    end

    assign databus = w_rd ? w_rdata : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_spart_gen2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spart_gen2
// Purpose  : Directed self-checking bench for spart_gen2 (TX FIFO fill, TX
//            bit timing, RX reception, parity/overrun/framing flags, glitch
//            rejection, interrupt, mid-frame reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spart_gen2;

    logic       clk = 1'b0;
    logic       rst, iocs_n, iorw_n, RX;
    logic [2:0] ioaddr;
    wire  [7:0] databus;
    logic       TX, tx_q_full, rx_q_empty;
`ifdef SPART_IRQ_EN
    logic       irq;
`endif
    logic       r_drv;
    logic [7:0] r_wdat;
    int         n_chk = 0;
    int         n_err = 0;

    assign databus = r_drv ? r_wdat : 8'hzz;
    always #5 clk = ~clk;

    spart_gen2 dut (
        .clk(clk), .rst(rst), .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr),
        .databus(databus), .RX(RX), .TX(TX), .tx_q_full(tx_q_full), .rx_q_empty(rx_q_empty)
`ifdef SPART_IRQ_EN
        , .irq(irq)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        ioaddr = a; r_wdat = d; r_drv = 1'b1; iorw_n = 1'b0; iocs_n = 1'b0;
        @(posedge clk); #1;
        iocs_n = 1'b1; iorw_n = 1'b1; r_drv = 1'b0;
        @(negedge clk);
    endtask

    // Read with no clock edge inside the access (no pop side effect).
    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        ioaddr = a; iorw_n = 1'b1; iocs_n = 1'b0;
        #1 d = databus;
        iocs_n = 1'b1;
    endtask

    // Read spanning one rising edge (pops RX FIFO for DATA).
    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        ioaddr = a; iorw_n = 1'b1; iocs_n = 1'b0;
        #1 d = databus;
        @(posedge clk); #1 iocs_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pchk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] v;
        peek(a, v);
        chk(tag, v, exp);
    endtask

    task automatic rchk(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        rd(3'd0, v);
        chk(tag, v, exp);
    endtask

    task automatic send(input logic [7:0] d, input int nb, input bit pen, input bit pb,
                        input bit sv, input int div);
        RX = 1'b0; idle(div);
        for (int i = 0; i < nb; i++) begin RX = d[i]; idle(div); end
        if (pen) begin RX = pb; idle(div); end
        RX = sv; idle(div);
        RX = 1'b1; idle(div);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        bit         done;
        logic [7:0] a5;
        rst = 1'b1; iocs_n = 1'b1; iorw_n = 1'b1; ioaddr = 3'd0;
        r_drv = 1'b0; r_wdat = 8'h00; RX = 1'b1;
        idle(3); rst = 1'b0; idle(1);

        // Reset state
        chk("rst_tx", TX, 1'b1);
        chk("rst_full", tx_q_full, 1'b0);
        chk("rst_empty", rx_q_empty, 1'b1);
        pchk("rst_stat", 3'd1, 8'h00);
        pchk("rst_dbl", 3'd2, 8'h64);
        pchk("rst_dbh", 3'd3, 8'h03);
        pchk("rst_ctrl", 3'd4, 8'h03);
        pchk("rst_txcnt", 3'd5, 8'h00);
        pchk("rst_rxcnt", 3'd6, 8'h00);
        pchk("rst_imsk", 3'd7, 8'h00);

        // TX FIFO fill: first byte is popped a cycle later, so 9 pushes fill it,
        // and the 10th must be dropped.
        wr(3'd2, 8'h10); wr(3'd3, 8'h00);
        for (int i = 0; i < 10; i++) wr(3'd0, 8'(i));
        chk("tx_full", tx_q_full, 1'b1);
        pchk("tx_cnt_full", 3'd5, 8'h08);
        done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            peek(3'd5, v);
            if (v == 8'h00) begin peek(3'd1, v); done = (v[0] == 1'b0); end
            if (!done) idle(1);
        end
        chk("tx_drain", done, 1'b1);

        // TX timing, divisor 217, 8N1, byte A5
        wr(3'd2, 8'hD9); wr(3'd3, 8'h00); wr(3'd4, 8'h03); wr(3'd0, 8'hA5);
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (TX == 1'b0) done = 1; else idle(1);
        end
        chk("tx_start_seen", done, 1'b1);
        a5 = 8'hA5;
        idle(108); chk("tx_start_mid", TX, 1'b0);
        idle(108); chk("tx_start_end", TX, 1'b0);
        idle(1);   chk("tx_bit0_edge", TX, a5[0]);
        idle(108);
        for (int i = 1; i < 8; i++) begin
            idle(217); chk($sformatf("tx_bit%0d", i), TX, a5[i]);
        end
        idle(217); chk("tx_stop", TX, 1'b1);
        idle(108); peek(3'd1, v); chk("tx_busy_last", v[0], 1'b1);
        idle(1);   peek(3'd1, v); chk("tx_busy_fall", v[0], 1'b0);

        // RX at divisor 868: glitch rejection, then two frames
        wr(3'd2, 8'h64); wr(3'd3, 8'h03);
        RX = 1'b0; idle(100); RX = 1'b1; idle(1000);
        pchk("glitch_rxcnt", 3'd6, 8'h00);
        pchk("glitch_stat", 3'd1, 8'h00);
        send(8'h3C, 8, 0, 0, 1, 868);
        send(8'hC3, 8, 0, 0, 1, 868);
        pchk("rx_cnt2", 3'd6, 8'h02);
        chk("rx_nempty", rx_q_empty, 1'b0);
        rchk("rx_data0", 8'h3C);
        rchk("rx_data1", 8'hC3);
        rchk("rx_empty_rd", 8'h00);
        chk("rx_empty", rx_q_empty, 1'b1);
        pchk("rx_cnt0", 3'd6, 8'h00);

        // Parity: 7 data bits, odd parity, divisor 32
        wr(3'd2, 8'h20); wr(3'd3, 8'h00); wr(3'd4, 8'h0E);
        send(8'h55, 7, 1, 0, 1, 32);
        pchk("par_stat", 3'd1, 8'h02);
        pchk("par_rxcnt", 3'd6, 8'h01);
        rchk("par_data", 8'h55);
        wr(3'd1, 8'h02);
        pchk("par_clear", 3'd1, 8'h00);
        send(8'hAA, 7, 1, 0, 1, 32);
        pchk("par_ok_stat", 3'd1, 8'h00);
        rchk("par_ok_data", 8'h2A);

        // Overrun: 9 frames into an 8-deep FIFO
        wr(3'd4, 8'h03);
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 8, 0, 0, 1, 32);
        pchk("ovr_rxcnt", 3'd6, 8'h08);
        pchk("ovr_stat", 3'd1, 8'h08);
        wr(3'd1, 8'h0E);
        pchk("ovr_clear", 3'd1, 8'h00);
        for (int i = 0; i < 8; i++) rchk($sformatf("ovr_data%0d", i), 8'h10 + 8'(i));
        chk("ovr_empty", rx_q_empty, 1'b1);

        // Framing: low stop bit
        send(8'h5A, 8, 0, 0, 0, 32);
        pchk("frm_stat", 3'd1, 8'h04);
        pchk("frm_rxcnt", 3'd6, 8'h00);
        wr(3'd1, 8'h0E);

`ifdef SPART_IRQ_EN
        wr(3'd7, 8'h01);
        pchk("imsk_rd", 3'd7, 8'h01);
        fork
            send(8'h77, 8, 0, 0, 1, 32);
        join_none
        done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (rx_q_empty == 1'b0) done = 1; else idle(1);
        end
        chk("irq_rx_seen", done, 1'b1);
        chk("irq_pre", irq, 1'b0);
        idle(1); chk("irq_rise", irq, 1'b1);
        idle(60);
        rchk("irq_data", 8'h77);
        chk("irq_hold", irq, 1'b1);
        idle(1); chk("irq_fall", irq, 1'b0);
        wr(3'd7, 8'h00);
`else
        wr(3'd7, 8'hFF);
        pchk("imsk_ignored", 3'd7, 8'h00);
`endif

        // Mid-frame reset
        wr(3'd0, 8'h00); wr(3'd0, 8'h00);
        idle(50);
        chk("mid_tx_low", TX, 1'b0);
        pchk("mid_txcnt", 3'd5, 8'h01);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_tx", TX, 1'b1);
        @(negedge clk); rst = 1'b0; idle(1);
        pchk("mid_rst_txcnt", 3'd5, 8'h00);
        pchk("mid_rst_dbl", 3'd2, 8'h64);
        chk("mid_rst_tx2", TX, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
